pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameters REG_ADDR_WIDTH, default 5, register-index width; CNT_WIDTH, default 16, performance-counter width.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have Rs1D, Rs2D  input  REG_ADDR_WIDTH each  source registers in Decode.
REQ-005 SHALL have Rs1E, Rs2E, RdE  input  REG_ADDR_WIDTH each  sources and destination in Execute.
REQ-006 SHALL have RdM, RdW  input  REG_ADDR_WIDTH each  destinations in Memory and Writeback.
REQ-007 SHALL have RegWriteM, RegWriteW  input  1 each  any nonzero RegWrite code in that stage, reduced to 1 bit by the datapath.
REQ-008 SHALL have LoadE  input  1  Execute instruction is a load (ResultSrcE selects memory).
REQ-009 SHALL have PCSrcE  input  1  taken branch or jump resolved in Execute.
REQ-010 SHALL have MemAccessM  input  1  load/store in Memory; mem_ready  input  1  data memory completes the access this cycle.
REQ-011 SHALL have ForwardAE, ForwardBE  output  2 each  00 register file, 10 ALUResultM, 01 ResultW.
REQ-012 SHALL have StallF, StallD, StallE, StallM, StallW  output  1 each  hold the named pipeline register.
REQ-013 SHALL have FlushD, FlushE  output  1 each  bubble into the named pipeline register.
REQ-014 SHALL have stall_cnt, flush_cnt  output  CNT_WIDTH each  performance counters.

Function
REQ-015 Forwarding SHALL be combinational: ForwardAE=10 if RegWriteM and RdM!=0 and RdM==Rs1E; else 01 if RegWriteW and RdW!=0 and RdW==Rs1E; else 00. ForwardBE likewise with Rs2E.
REQ-016 Forwarding SHALL give the Memory-stage match priority over the Writeback-stage match.
REQ-017 Load-use hazard lwStall SHALL be LoadE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-018 FSM SHALL have states IDLE and MEM_WAIT.
REQ-019 IDLE->MEM_WAIT when MemAccessM and not mem_ready; MEM_WAIT->IDLE when mem_ready; all other cases hold state.
REQ-020 memStall SHALL be (IDLE and MemAccessM and not mem_ready) or (MEM_WAIT and not mem_ready); zero added latency when mem_ready is high on the first cycle.
REQ-021 On memStall: all five Stall outputs SHALL be 1 and FlushD=FlushE=0, overriding lwStall and PCSrcE.
REQ-022 A branch held in Execute during memStall SHALL flush on the first cycle after release, because PCSrcE remains asserted.
REQ-023 Otherwise: StallF=StallD=lwStall; StallE=StallM=StallW=0; FlushD=PCSrcE; FlushE=lwStall or PCSrcE.
REQ-024 When lwStall and PCSrcE coincide, StallF/StallD SHALL be 1 and FlushD=FlushE=1.
REQ-025 stall_cnt SHALL increment once per cycle in which StallF=1; flush_cnt once per cycle in which FlushD or FlushE=1.
REQ-026 Both counters SHALL saturate at all-ones with no wrap.
REQ-027 Counter updates SHALL be registered, visible one cycle after the event.

Reset
REQ-028 While rst=1: state=IDLE, stall_cnt=0, flush_cnt=0.
REQ-029 Combinational outputs SHALL follow REQ-015..REQ-024 using the IDLE state.
REQ-030 rst asserted mid MEM_WAIT SHALL return to IDLE immediately, with no pending flush retained.

Structure
REQ-031 The forwarding-select encodings and the FSM state enum SHALL live in the shared pipeline package.
REQ-032 One sub-module, forward_sel, SHALL compute a single 2-bit forward select and be instantiated twice (A and B).

Verification
REQ-033 RdM=5, RegWriteM=1, Rs1E=5, RdW=5, RegWriteW=1 -> ForwardAE=10; with RdM=0 instead -> ForwardAE=01.
REQ-034 LoadE=1, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=1, FlushE=1, FlushD=0; stall_cnt +1 next cycle.
REQ-035 MemAccessM=1, mem_ready low for 3 cycles then high -> all Stall outputs 1 for exactly 3 cycles, state back to IDLE, stall_cnt +3.
REQ-036 PCSrcE=1 during a 2-cycle memory wait -> FlushD/FlushE 0 during the wait, 1 on the release cycle, flush_cnt +1.
REQ-037 Preload stall_cnt to all-ones via a long wait, then one more stall -> stall_cnt stays at all-ones.
REQ-038 rst pulsed mid MEM_WAIT -> state IDLE and counters 0 asynchronously; no flush on the following cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: forwarding-select encodings and hazard FSM states.
package pipeline_hazard_ctrl_pkg;

  // Execute-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register file value from Decode
    FWD_WB  = 2'b01,  // ResultW
    FWD_MEM = 2'b10   // ALUResultM
  } fwd_sel_e;

  // Data-memory wait tracking
  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// Single-operand forwarding selector; Memory-stage match wins over Writeback.
module forward_sel
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  output logic [1:0]                fwd
);

  // Priority select of the newest in-flight producer; x0 never forwards
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs))
      fwd = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
      fwd = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use and memory-wait stalls,
// branch flushes, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      LoadE,
  input  logic                      PCSrcE,
  input  logic                      MemAccessM,
  input  logic                      mem_ready,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      StallW,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  hz_state_e state, next_state;
  logic      lw_stall;
  logic      mem_stall;

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (ForwardAE)
  );

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (ForwardBE)
  );

  // Load in Execute whose destination is read by the instruction in Decode
  always_comb begin
    lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Memory-wait state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state, memory stall and the stall/flush outputs; a memory stall
  // freezes the whole pipe so any branch in Execute flushes after release
  always_comb begin
    next_state = state;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (MemAccessM && !mem_ready) begin
          next_state = MEM_WAIT;
          mem_stall  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) next_state = IDLE;
        else           mem_stall  = 1'b1;
      end
      default: next_state = IDLE;
    endcase

    StallF = lw_stall;
    StallD = lw_stall;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = PCSrcE;
    FlushE = lw_stall || PCSrcE;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
    end
  end

  // Saturating performance counters, updated the cycle after each event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if ((FlushD || FlushE) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with narrow counters so saturation is reachable.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned CW  = 4;
  localparam int          MAXC = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM, mem_ready;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [CW-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string      tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [4:0] stalls;  // {F,D,E,M,W}
    logic [1:0] flushes; // {D,E}
    int         sc;
    int         fc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   sc_m     = 0;
  int   fc_m     = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .mem_ready(mem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare outputs mid-cycle against the expectation queued for this cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, "_fa"},    32'(ForwardAE), 32'(e.fa));
      check({e.tag, "_fb"},    32'(ForwardBE), 32'(e.fb));
      check({e.tag, "_stall"}, 32'({StallF, StallD, StallE, StallM, StallW}), 32'(e.stalls));
      check({e.tag, "_flush"}, 32'({FlushD, FlushE}), 32'(e.flushes));
      check({e.tag, "_scnt"},  32'(stall_cnt), 32'(e.sc));
      check({e.tag, "_fcnt"},  32'(flush_cnt), 32'(e.fc));
    end
  end

  // Queue this cycle's expectation, then advance and account for counter events
  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [4:0] stalls, input logic [1:0] flushes);
    exp_t e;
    e.tag = tag; e.fa = fa; e.fb = fb; e.stalls = stalls; e.flushes = flushes;
    e.sc = sc_m; e.fc = fc_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (stalls[4] && sc_m < MAXC) sc_m++;
    if ((flushes != 2'b00) && fc_m < MAXC) fc_m++;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0;
    MemAccessM = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    #2;
    check("rst_scnt", 32'(stall_cnt), 32'd0);
    check("rst_fcnt", 32'(flush_cnt), 32'd0);
    check("rst_stall", 32'(StallF), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Forwarding
    RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1;
    step("fwd_mem", 2'b10, 2'b00, 5'b00000, 2'b00);
    RdM = 0;
    step("fwd_wb", 2'b01, 2'b00, 5'b00000, 2'b00);
    RdM = 3; Rs2E = 3; Rs1E = 9; RdW = 9;
    step("fwd_b", 2'b01, 2'b10, 5'b00000, 2'b00);
    RegWriteM = 0; RegWriteW = 0;
    step("fwd_nowe", 2'b00, 2'b00, 5'b00000, 2'b00);
    RegWriteM = 1; RegWriteW = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    step("fwd_x0", 2'b00, 2'b00, 5'b00000, 2'b00);
    clear_inputs();

    // Load-use and branch
    LoadE = 1; RdE = 7; Rs2D = 7;
    step("lw_rs2", 2'b00, 2'b00, 5'b11000, 2'b01);
    Rs2D = 0; Rs1D = 7;
    step("lw_rs1", 2'b00, 2'b00, 5'b11000, 2'b01);
    RdE = 0; Rs1D = 0;
    step("lw_rd0", 2'b00, 2'b00, 5'b00000, 2'b00);
    LoadE = 0; RdE = 7; Rs1D = 7;
    step("lw_noload", 2'b00, 2'b00, 5'b00000, 2'b00);
    PCSrcE = 1;
    step("branch", 2'b00, 2'b00, 5'b00000, 2'b11);
    LoadE = 1;
    step("lw_branch", 2'b00, 2'b00, 5'b11000, 2'b11);
    clear_inputs();

    // Three-cycle memory wait
    MemAccessM = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) step("memwait3", 2'b00, 2'b00, 5'b11111, 2'b00);
    mem_ready = 1;
    step("mem_rel", 2'b00, 2'b00, 5'b00000, 2'b00);
    MemAccessM = 0; mem_ready = 0;
    step("mem_idle", 2'b00, 2'b00, 5'b00000, 2'b00);

    // Branch held through a two-cycle wait, load-use overridden while waiting
    MemAccessM = 1; PCSrcE = 1;
    step("br_wait1", 2'b00, 2'b00, 5'b11111, 2'b00);
    LoadE = 1; RdE = 7; Rs1D = 7;
    step("br_wait2", 2'b00, 2'b00, 5'b11111, 2'b00);
    LoadE = 0; mem_ready = 1;
    step("br_rel", 2'b00, 2'b00, 5'b00000, 2'b11);
    clear_inputs();
    step("br_after", 2'b00, 2'b00, 5'b00000, 2'b00);

    // Drive stall_cnt into saturation, then one more stall
    MemAccessM = 1;
    for (int i = 0; i < 10; i++) step("sat_wait", 2'b00, 2'b00, 5'b11111, 2'b00);
    mem_ready = 1;
    step("sat_rel", 2'b00, 2'b00, 5'b00000, 2'b00);
    clear_inputs();
    LoadE = 1; RdE = 4; Rs2D = 4;
    step("sat_lw", 2'b00, 2'b00, 5'b11000, 2'b01);
    clear_inputs();
    step("sat_hold", 2'b00, 2'b00, 5'b00000, 2'b00);

    // Reset in the middle of a wait with a branch pending
    MemAccessM = 1; PCSrcE = 1;
    step("rst_wait", 2'b00, 2'b00, 5'b11111, 2'b00);
    rst = 1'b1;
    clear_inputs();
    #1;
    check("arst_scnt", 32'(stall_cnt), 32'd0);
    check("arst_fcnt", 32'(flush_cnt), 32'd0);
    check("arst_stall", 32'({StallF, StallE}), 32'd0);
    check("arst_flush", 32'({FlushD, FlushE}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    sc_m = 0; fc_m = 0;
    step("post_rst1", 2'b00, 2'b00, 5'b00000, 2'b00);
    step("post_rst2", 2'b00, 2'b00, 5'b00000, 2'b00);

    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
